// File: rtl/filt_ctrl_pkg.sv
// Shared types and constants for the FIR sequencing controller and the filter instances it drives.
package filt_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PRIME,
    ST_WAIT,
    ST_SEQ,
    ST_FLUSH,
    ST_DONE
  } seq_state_t;

  localparam int DEF_NUM_TAPS    = 1021;
  localparam int DEF_PRIME_SMPLS = 1021;
  localparam int DEF_PIPE_LAT    = 2;

  // Accumulator bits taken by the filter outputs on out_en.
  localparam int ACC_OUT_MSB = 30;
  localparam int ACC_OUT_LSB = 15;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/filt_seq_ctrl_tap_addr_cnt.sv
// Tap address counter: synchronous clear, count enable, wraps to 0 after the terminal tap.
module tap_addr_cnt
  import filt_ctrl_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  output logic [$clog2(NUM_TAPS)-1:0] addr,
  output logic                        tc
);

  localparam int AW = $clog2(NUM_TAPS);
  localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);

  assign tc = (addr == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      addr <= '0;
    end else if (en) begin
      addr <= tc ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/filt_seq_ctrl.sv
// Per-sample sequencer for the shared FIR MAC datapath (priming, tap burst, pipeline drain, capture).
// Optional macro OVR_CNT_EN adds a saturating overrun event counter output ovr_cnt.
module filt_seq_ctrl
  import filt_ctrl_pkg::*;
#(
  parameter int NUM_TAPS    = DEF_NUM_TAPS,
  parameter int PRIME_SMPLS = DEF_PRIME_SMPLS,
  parameter int PIPE_LAT    = DEF_PIPE_LAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        smpl_valid,
  input  logic                        flush,
  output logic                        sequencing,
  output logic [$clog2(NUM_TAPS)-1:0] addr,
  output logic                        acc_clr,
  output logic                        out_en,
  output logic                        busy,
  output logic                        overrun
`ifdef OVR_CNT_EN
  , output logic [7:0]                ovr_cnt
`endif
);

  localparam int PW = $clog2(PRIME_SMPLS + 1);
  localparam int LW = cnt_width(PIPE_LAT);
  localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_SMPLS - 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  seq_state_t    state, state_nxt;
  logic [PW-1:0] prime_cnt, prime_nxt;
  logic [LW-1:0] lat_cnt;
  logic          pending, pending_nxt;
  logic          ovr_hit;
  logic          tc;

  tap_addr_cnt #(
    .NUM_TAPS(NUM_TAPS)
  ) u_addr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (state == ST_SEQ),
    .addr(addr),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PRIME;
      prime_cnt <= '0;
      pending   <= 1'b0;
      lat_cnt   <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      prime_cnt <= prime_nxt;
      pending   <= pending_nxt;
      lat_cnt   <= (state == ST_FLUSH) ? lat_cnt + 1'b1 : '0;
      if (ovr_hit) overrun <= 1'b1;
    end
  end

`ifdef OVR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt <= '0;
    end else if (ovr_hit && (ovr_cnt != 8'hFF)) begin
      ovr_cnt <= ovr_cnt + 8'd1;
    end
  end
`else
  // Only the sticky overrun flag is kept in this build.
`endif

  always_comb begin
    state_nxt   = state;
    prime_nxt   = prime_cnt;
    pending_nxt = pending;
    ovr_hit     = 1'b0;
    if (flush) begin
      state_nxt   = ST_PRIME;
      prime_nxt   = '0;
      pending_nxt = 1'b0;
    end else begin
      case (state)
        ST_PRIME: begin
          if (smpl_valid) begin
            prime_nxt = prime_cnt + 1'b1;
            if (prime_cnt == PRIME_LAST) state_nxt = ST_SEQ;
          end
        end
        ST_WAIT: begin
          if (smpl_valid) state_nxt = ST_SEQ;
        end
        ST_SEQ, ST_FLUSH: begin
          if (state == ST_SEQ) begin
            if (tc) state_nxt = (PIPE_LAT == 0) ? ST_DONE : ST_FLUSH;
          end else if (lat_cnt == LAT_LAST) begin
            state_nxt = ST_DONE;
          end
          if (smpl_valid) begin
            if (pending) ovr_hit = 1'b1;
            else         pending_nxt = 1'b1;
          end
        end
        ST_DONE: begin
          state_nxt   = (pending || smpl_valid) ? ST_SEQ : ST_WAIT;
          // A pending pass starts now, so a new sample here takes its freed slot.
          pending_nxt = pending && smpl_valid;
        end
        default: state_nxt = ST_PRIME;
      endcase
    end
  end

  always_comb begin
    sequencing = (state == ST_SEQ);
    acc_clr    = (state == ST_SEQ) && (addr == '0);
    out_en     = (state == ST_DONE) && !flush;
    busy       = (state == ST_SEQ) || (state == ST_FLUSH) || (state == ST_DONE);
  end

endmodule

// File: tb/tb_filt_seq_ctrl.sv
// Directed self-checking bench for filt_seq_ctrl with NUM_TAPS=8, PRIME_SMPLS=4, PIPE_LAT=2.
module tb_filt_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       smpl_valid = 1'b0;
  logic       flush = 1'b0;
  logic       sequencing;
  logic [2:0] addr;
  logic       acc_clr;
  logic       out_en;
  logic       busy;
  logic       overrun;
`ifdef OVR_CNT_EN
  logic [7:0] ovr_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  always #5 clk = ~clk;

  filt_seq_ctrl #(
    .NUM_TAPS   (8),
    .PRIME_SMPLS(4),
    .PIPE_LAT   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .smpl_valid(smpl_valid),
    .flush     (flush),
    .sequencing(sequencing),
    .addr      (addr),
    .acc_clr   (acc_clr),
    .out_en    (out_en),
    .busy      (busy),
    .overrun   (overrun)
`ifdef OVR_CNT_EN
    , .ovr_cnt (ovr_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc_no, obs, exp);
    end
  endtask

  // Advance one clock, drive this cycle's inputs, then let outputs settle.
  task automatic cyc(input logic sv, input logic fl, input logic r);
    @(posedge clk);
    #1;
    cyc_no++;
    smpl_valid = sv;
    flush      = fl;
    rst        = r;
    #1;
  endtask

  // Step k cycles after the strobe that launched the current pass.
  task automatic pass_step(input int k, input logic sv);
    cyc(sv, 1'b0, 1'b0);
    chk("seq",     sequencing, (k >= 1 && k <= 8));
    chk("addr",    addr,       (k >= 1 && k <= 8) ? k - 1 : 0);
    chk("acc_clr", acc_clr,    (k == 1));
    chk("out_en",  out_en,     (k == 11));
    chk("busy",    busy,       (k >= 1 && k <= 11));
  endtask

  task automatic idle_chk(input logic sv);
    cyc(sv, 1'b0, 1'b0);
    chk("idle_seq",  sequencing, 0);
    chk("idle_busy", busy,       0);
    chk("idle_oen",  out_en,     0);
  endtask

  initial begin
    // Reset
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("rst_seq", sequencing, 0);
    chk("rst_addr", addr, 0);
    chk("rst_acc_clr", acc_clr, 0);
    chk("rst_out_en", out_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
`ifdef OVR_CNT_EN
    chk("rst_ovr_cnt", ovr_cnt, 0);
`endif

    // Priming: three strobes start nothing, the fourth launches a pass
    for (int i = 0; i < 3; i++) begin
      idle_chk(1);
      idle_chk(0);
    end
    idle_chk(1);
    for (int k = 1; k <= 12; k++) pass_step(k, 0);

    // Back-to-back: second strobe at t+5 queues one pass starting at t+12
    idle_chk(1);
    for (int k = 1; k <= 11; k++) pass_step(k, k == 5);
    for (int k = 1; k <= 12; k++) pass_step(k, 0);
    chk("b2b_overrun", overrun, 0);

    // Overrun: strobes at t, t+3, t+6, t+7
    idle_chk(1);
    for (int k = 1; k <= 6; k++) pass_step(k, (k == 3) || (k == 6));
    chk("ovr_before", overrun, 0);
    pass_step(7, 1);
    chk("ovr_set", overrun, 1);
    pass_step(8, 0);
`ifdef OVR_CNT_EN
    chk("ovr_cnt2", ovr_cnt, 2);
`endif
    for (int k = 9; k <= 11; k++) pass_step(k, 0);
    for (int k = 1; k <= 12; k++) pass_step(k, 0);
    idle_chk(0);
    idle_chk(0);
    chk("ovr_sticky", overrun, 1);

    // Flush mid-pass at addr==3
    idle_chk(1);
    for (int k = 1; k <= 3; k++) pass_step(k, 0);
    cyc(0, 1, 0);
    chk("fl_seq_now", sequencing, 1);
    chk("fl_addr_now", addr, 3);
    for (int i = 0; i < 8; i++) begin
      idle_chk(0);
      chk("fl_addr", addr, 0);
      chk("fl_acc_clr", acc_clr, 0);
    end
    chk("fl_overrun", overrun, 1);
    for (int i = 0; i < 3; i++) idle_chk(1);
    idle_chk(0);
    idle_chk(1);
    for (int k = 1; k <= 12; k++) pass_step(k, 0);

    // Flush with simultaneous strobe: strobe not counted
    cyc(1, 1, 0);
    idle_chk(0);
    chk("fs_overrun", overrun, 1);
    for (int i = 0; i < 3; i++) idle_chk(1);
    idle_chk(0);
    idle_chk(1);
    // Strobe during DONE with nothing pending starts the next pass directly
    for (int k = 1; k <= 11; k++) pass_step(k, k == 11);
    for (int k = 1; k <= 5; k++) pass_step(k, 0);

    // Synchronous reset at addr==5 with overrun set
    cyc(0, 0, 1);
    chk("rr_addr_now", addr, 5);
    chk("rr_ovr_now", overrun, 1);
    cyc(0, 0, 0);
    chk("rr_seq", sequencing, 0);
    chk("rr_addr", addr, 0);
    chk("rr_acc_clr", acc_clr, 0);
    chk("rr_out_en", out_en, 0);
    chk("rr_busy", busy, 0);
    chk("rr_overrun", overrun, 0);
`ifdef OVR_CNT_EN
    chk("rr_ovr_cnt", ovr_cnt, 0);
`endif
    for (int i = 0; i < 3; i++) idle_chk(1);
    idle_chk(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
